// File: rtl/com_intc_pkg.sv
// Shared definitions for the COM-bus interrupt controller: register offsets,
// controller states and the flag-byte layout presented to the core.
package intc_pkg;

  localparam logic [7:0] INTC_PEND = 8'd0;
  localparam logic [7:0] INTC_MASK = 8'd1;
  localparam logic [7:0] INTC_EOI  = 8'd2;
  localparam logic [7:0] INTC_SWI  = 8'd3;
  localparam logic [7:0] INTC_STAT = 8'd4;
  localparam int         INTC_NREGS = 5;

  localparam int INTC_FLAG_VALID_BIT = 7;
  localparam int INTC_STAT_INSVC_BIT = 7;
  localparam int INTC_STAT_IRQ_BIT   = 6;

  typedef enum logic [1:0] {
    INTC_IDLE,
    INTC_FIRE,
    INTC_SERVICE
  } intc_state_t;

  // Byte the datapath latches as its interrupt flag during the pulse.
  function automatic logic [7:0] intc_flag(input logic [2:0] id);
    logic [7:0] f;
    f = '0;
    f[INTC_FLAG_VALID_BIT] = 1'b1;
    f[2:0] = id;
    return f;
  endfunction

endpackage

// File: rtl/com_intc_if.sv
// COM port plus interrupt lines between the risc8 core side and the
// interrupt controller.
interface com_intc_if #(
  parameter int NSRC = 8
);
  logic [7:0]      com_addr;
  logic [7:0]      com_wr;
  logic            com_we;
  logic [7:0]      com_rd;
  logic [NSRC-1:0] irq_in;
  logic            interrupt;

  modport master (output com_addr, com_wr, com_we, irq_in,
                  input  com_rd, interrupt);
  modport slave  (input  com_addr, com_wr, com_we, irq_in,
                  output com_rd, interrupt);
endinterface

// File: rtl/com_intc_prio_enc.sv
// Combinational priority encoder: the lowest set request index wins.
module intc_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      id
);

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    valid = 1'b0;
    id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/com_intc.sv
// COM-bus interrupt controller for risc8: edge-detects up to eight sources,
// masks/prioritises them and fires a one-cycle pulse, then waits for EOI.
// Define COM_INTC_SYNC_EN to add a 2-flop synchroniser on every irq_in bit.
module com_intc
  import intc_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NSRC      = 8
) (
  input  logic      clk,
  input  logic      rst,
  com_intc_if.slave bus
);

  intc_state_t     state_q, state_d;
  logic [2:0]      id_q, id_d;
  logic            interrupt_q, interrupt_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] irq_prev_q, irq_prev_d;
  logic [NSRC-1:0] irq_s, edge_det, w1c, swi_set, fire_clr;
  logic [7:0]      off, rd_data;
  logic            hit, wr_pend, wr_mask, wr_eoi, wr_swi;
  logic            grant_valid;
  logic [2:0]      grant_id;

`ifdef COM_INTC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq_in;
`endif

  // Address 0 is bus idle; the modulo offset test also covers windows near 8'hFF.
  assign off     = bus.com_addr - BASE_ADDR;
  assign hit     = (bus.com_addr != 8'h00) && (off < 8'(INTC_NREGS));
  assign wr_pend = bus.com_we && hit && (off == INTC_PEND);
  assign wr_mask = bus.com_we && hit && (off == INTC_MASK);
  assign wr_eoi  = bus.com_we && hit && (off == INTC_EOI);
  assign wr_swi  = bus.com_we && hit && (off == INTC_SWI);

  assign edge_det = irq_s & ~irq_prev_q;
  assign w1c      = wr_pend ? bus.com_wr[NSRC-1:0] : '0;
  assign swi_set  = wr_swi  ? bus.com_wr[NSRC-1:0] : '0;

  intc_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (pend_q & mask_q),
    .valid (grant_valid),
    .id    (grant_id)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    mask_d     = wr_mask ? bus.com_wr[NSRC-1:0] : mask_q;
    irq_prev_d = irq_s;
    fire_clr   = '0;
    unique case (state_q)
      INTC_IDLE: begin
        if (grant_valid) begin
          state_d  = INTC_FIRE;
          id_d     = grant_id;
          fire_clr = NSRC'(1) << grant_id;
        end
      end
      INTC_FIRE:    state_d = INTC_SERVICE;
      INTC_SERVICE: if (wr_eoi) state_d = INTC_IDLE;
      default:      state_d = INTC_IDLE;
    endcase
    // Sets are applied last so an edge or SWI always beats a clear.
    pend_d      = (pend_q & ~w1c & ~fire_clr) | edge_det | swi_set;
    interrupt_d = (state_d == INTC_FIRE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values; reset is synchronous.
    if (rst) begin
      state_q     <= INTC_IDLE;
      id_q        <= '0;
      interrupt_q <= 1'b0;
      pend_q      <= '0;
      mask_q      <= '0;
      irq_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      interrupt_q <= interrupt_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      irq_prev_q  <= irq_prev_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (state_q == INTC_FIRE) begin
      rd_data = intc_flag(id_q);
    end else if (hit) begin
      case (off)
        INTC_PEND: rd_data = 8'(pend_q);
        INTC_MASK: rd_data = 8'(mask_q);
        INTC_STAT: begin
          rd_data[INTC_STAT_INSVC_BIT] = (state_q == INTC_SERVICE);
          rd_data[INTC_STAT_IRQ_BIT]   = interrupt_q;
          rd_data[2:0]                 = id_q;
        end
        default:   rd_data = '0;
      endcase
    end
  end

  assign bus.com_rd    = rd_data;
  assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_com_intc.sv
// Self-checking bench for com_intc (default build): vector table, directed
// corner sequences, then random traffic against a behavioural model.
module tb_com_intc;

  localparam logic [7:0] BASE = 8'hF0;
  localparam int P_IDLE = 0, P_FIRE = 1, P_SVC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  com_intc_if #(.NSRC(8)) bus ();
  com_intc #(.BASE_ADDR(BASE), .NSRC(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] irq;
    logic [7:0] exp_rd;
    logic       exp_int;
  } vec_t;
  vec_t vecs[17];

  // Behavioural model state
  bit [7:0] m_pend, m_mask, m_prev;
  int       m_phase;
  bit [2:0] m_id;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.com_addr = 8'h00;
    bus.com_wr   = 8'h00;
    bus.com_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    bus.irq_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.com_addr = a;
    bus.com_wr   = d;
    bus.com_we   = 1'b1;
    tick();
    idle_bus();
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus.com_addr = a;
    bus.com_we   = 1'b0;
    #1;
    check(name, bus.com_rd, exp);
    bus.com_addr = 8'h00;
  endtask

  task automatic int_chk(input string name, input logic exp);
    check(name, {7'b0, bus.interrupt}, {7'b0, exp});
  endtask

  task automatic fire_chk(input string name, input logic [7:0] flag);
    int_chk({name, " int"}, 1'b1);
    check({name, " flag"}, bus.com_rd, flag);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      if (bus.interrupt) n++;
      tick();
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] addr);
    if (m_phase == P_FIRE) return {1'b1, 4'b0000, m_id};
    if (addr == 8'h00 || addr < BASE || addr > BASE + 8'd4) return 8'h00;
    case (addr - BASE)
      8'd0:    return m_pend;
      8'd1:    return m_mask;
      8'd4:    return {m_phase == P_SVC, m_phase == P_FIRE, 3'b000, m_id};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_step(input logic [7:0] addr, input logic [7:0] d, input logic we,
                        input logic [7:0] irq);
    bit [7:0] nxt;
    int       win;
    bit       hit;
    int       reg_n;
    hit   = we && addr >= BASE && addr <= BASE + 8'd4;
    reg_n = int'(addr - BASE);
    win   = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_pend[i] && m_mask[i]) begin
        win = i;
        break;
      end
    end
    nxt = m_pend;
    if (hit && reg_n == 0) nxt &= ~d;
    if (m_phase == P_IDLE && win >= 0) nxt[win] = 1'b0;
    nxt |= irq & ~m_prev;
    if (hit && reg_n == 3) nxt |= d;
    if (m_phase == P_IDLE && win >= 0) begin
      m_phase = P_FIRE;
      m_id    = 3'(win);
    end else if (m_phase == P_FIRE) begin
      m_phase = P_SVC;
    end else if (m_phase == P_SVC && hit && reg_n == 2) begin
      m_phase = P_IDLE;
    end
    if (hit && reg_n == 1) m_mask = d;
    m_pend = nxt;
    m_prev = irq;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] irq_r;

    // addr, wdata, we, irq, exp_rd, exp_int
    vecs[0]  = '{8'hF0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{8'hF1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{8'hF2, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{8'hF3, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{8'hF4, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{8'hF5, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{8'hF1, 8'h04, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{8'hF1, 8'h00, 1'b0, 8'h04, 8'h04, 1'b0};
    vecs[8]  = '{8'hF0, 8'h00, 1'b0, 8'h04, 8'h04, 1'b0};
    vecs[9]  = '{8'hF3, 8'h00, 1'b0, 8'h04, 8'h82, 1'b1};
    vecs[10] = '{8'hF0, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0};
    vecs[11] = '{8'hF4, 8'h00, 1'b0, 8'h04, 8'h82, 1'b0};
    vecs[12] = '{8'hF2, 8'h00, 1'b1, 8'h04, 8'h00, 1'b0};
    vecs[13] = '{8'hF4, 8'h00, 1'b0, 8'h04, 8'h02, 1'b0};
    vecs[14] = '{8'h00, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0};
    vecs[15] = '{8'hF2, 8'h55, 1'b1, 8'h04, 8'h00, 1'b0};
    vecs[16] = '{8'hF4, 8'h00, 1'b0, 8'h04, 8'h02, 1'b0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.com_addr = vecs[i].addr;
      bus.com_wr   = vecs[i].wdata;
      bus.com_we   = vecs[i].we;
      bus.irq_in   = vecs[i].irq;
      #1;
      check($sformatf("vec%0d rd", i), bus.com_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d int", i), {7'b0, bus.interrupt}, {7'b0, vecs[i].exp_int});
      tick();
    end
    idle_bus();

    // Two simultaneous sources: lowest first, the other right after EOI.
    do_reset();
    wr(8'hF1, 8'hFF);
    bus.irq_in = 8'h22;
    tick();
    int_chk("A edge cycle", 1'b0);
    tick();
    fire_chk("A first", 8'h81);
    tick();
    int_chk("A single pulse", 1'b0);
    rd_chk("A pend left", 8'hF0, 8'h20);
    wr(8'hF2, 8'h00);
    int_chk("A eoi cycle", 1'b0);
    tick();
    fire_chk("A second", 8'h85);
    tick();

    // New edge while in service: pending but no nested pulse.
    bus.irq_in = 8'h23;
    tick();
    count_pulses(4, n);
    check("B no nesting", 8'(n), 8'h00);
    rd_chk("B pend", 8'hF0, 8'h01);
    wr(8'hF2, 8'h00);
    int_chk("B eoi cycle", 1'b0);
    tick();
    fire_chk("B after eoi", 8'h80);
    tick();

    // W1C racing a new edge, plain W1C, then a software interrupt.
    do_reset();
    bus.irq_in = 8'h08;
    tick();
    rd_chk("C pend set", 8'hF0, 8'h08);
    bus.irq_in = 8'h00;
    tick();
    bus.irq_in = 8'h08;
    wr(8'hF0, 8'h08);
    rd_chk("C set beats clr", 8'hF0, 8'h08);
    wr(8'hF0, 8'h08);
    rd_chk("C w1c", 8'hF0, 8'h00);
    wr(8'hF1, 8'h10);
    wr(8'hF3, 8'h10);
    int_chk("C swi edge", 1'b0);
    rd_chk("C swi pend", 8'hF0, 8'h10);
    tick();
    fire_chk("C swi fire", 8'h84);
    tick();

    // Reset in the middle of service.
    do_reset();
    wr(8'hF1, 8'h01);
    bus.irq_in = 8'h01;
    tick();
    tick();
    fire_chk("D fire", 8'h80);
    tick();
    bus.irq_in = 8'h03;
    tick();
    rd_chk("D stat svc", 8'hF4, 8'h80);
    rd_chk("D pend svc", 8'hF0, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("D stat rst", 8'hF4, 8'h00);
    rd_chk("D pend rst", 8'hF0, 8'h00);
    rd_chk("D mask rst", 8'hF1, 8'h00);
    int_chk("D int rst", 1'b0);
    bus.irq_in = 8'h00;
    tick();
    bus.irq_in = 8'h01;
    count_pulses(5, n);
    check("D masked no pulse", 8'(n), 8'h00);
    rd_chk("D pend masked", 8'hF0, 8'h01);

    // Random traffic against the model.
    do_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_phase = P_IDLE; m_id = '0;
    irq_r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 15);
      bus.com_we   = 1'b0;
      bus.com_wr   = 8'($urandom);
      bus.com_addr = 8'h00;
      case (r)
        0, 1, 2, 3, 4, 5: bus.com_addr = BASE + 8'($urandom_range(0, 5));
        6:  bus.com_addr = 8'($urandom);
        7:  begin bus.com_addr = BASE + 8'd1; bus.com_we = 1'b1; end
        8:  begin bus.com_addr = BASE;        bus.com_we = 1'b1; end
        9, 10: begin bus.com_addr = BASE + 8'd2; bus.com_we = 1'b1; end
        11: begin
          bus.com_addr = BASE + 8'd3;
          bus.com_we   = 1'b1;
          bus.com_wr   = 8'($urandom & $urandom & $urandom);
        end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) irq_r = irq_r ^ (8'h01 << $urandom_range(0, 7));
      bus.irq_in = irq_r;
      #1;
      check("rand rd", bus.com_rd, m_read(bus.com_addr));
      check("rand int", {7'b0, bus.interrupt}, {7'b0, m_phase == P_FIRE});
      m_step(bus.com_addr, bus.com_wr, bus.com_we, bus.irq_in);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/com_intc.md
# com_intc

COM-bus interrupt controller for the risc8 core. Sits as a responder on the core's 8-bit COM port and drives the core's `interrupt` input. It collects up to eight peripheral interrupt sources, masks and prioritises them, and fires a single-cycle interrupt pulse. During that pulse it presents a flag byte on `com_rd`, which the datapath latches as its interrupt flag. It then holds off further interrupts until software writes end-of-interrupt.

## Interface
- `BASE_ADDR`, 8'hF0: COM address of register 0. Registers occupy `BASE_ADDR`..`BASE_ADDR+4`. Must be nonzero, because address 0 means bus idle.
- `NSRC`, 8: number of sources, 1..8. Bits at and above `NSRC` read 0 and ignore writes.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `com_addr`  in  8  COM register address. The core drives 0 when idle.
- `com_wr`  in  8  COM write data.
- `com_we`  in  1  write strobe. A write takes effect at the clock edge when `com_we` is high and `com_addr` hits.
- `com_rd`  out  8  read data. Combinational from registers.
- `irq_in`  in  NSRC  level source lines. A rising edge requests service.
- `interrupt`  out  1  registered pulse to the core, one cycle wide.

## Operation
Registers, at offset from `BASE_ADDR`:
- 0 PEND: read returns pending bits. Write 1 to a bit to clear it.
- 1 MASK: read/write. 1 means enabled. Reset value 0, all sources masked.
- 2 EOI: a write of any data ends service. Reads return 0.
- 3 SWI: write 1 to a bit to set that pending bit (software interrupt). Reads return 0.
- 4 STAT: read only. Bit 7 = in service, bit 6 = interrupt output, bits 2:0 = active id.

Edge detection:
- `irq_prev` is registered from `irq_in`.
- A bit becomes pending when `irq_in & ~irq_prev` is set for it.

Bit-set rule when events coincide in one cycle:
- A hardware edge or SWI set beats a PEND W1C clear on the same bit.

Grant:
- Priority encoder over `PEND & MASK`. The lowest index wins.

State machine:
- IDLE: when the grant is valid, go to FIRE. Latch `id`, and clear that pending bit at the same edge.
- FIRE: `interrupt` = 1 for exactly one cycle, then go to SERVICE.
- SERVICE: wait for an EOI write, then go to IDLE. New edges still set pending bits, but no fire occurs (no nesting).

EOI handling:
- EOI written in IDLE or FIRE is ignored.
- EOI and a valid grant in the same SERVICE cycle: go to IDLE only. The next fire comes one cycle later.

`com_rd`:
- In FIRE, `com_rd` = flag byte `{1'b1, 4'b0000, id[2:0]}`, regardless of address.
- Otherwise, `com_rd` = the addressed register, or 0 on a miss or for address 0.

Reset value of every output and state:
- `interrupt` = 0, `com_rd` = 0.
- PEND = 0, MASK = 0, `irq_prev` = 0, `id` = 0, state = IDLE.
- Reset in any state, including mid-SERVICE, returns to IDLE with everything cleared.

## Timing
- Source edge sampled at clock edge k: PEND bit visible after k. State goes FIRE after k+1, so `interrupt` is high from k+1 to k+2.
- Latency is 2 cycles from first sampled high to pulse, when unmasked and IDLE.
- A MASK write enabling an already-pending bit at edge k: FIRE after k+1.
- An EOI write at edge k with a pending enabled bit: IDLE after k, FIRE after k+1, pulse from k+1 to k+2.
- Register writes take effect at the strobe edge. Reads are same-cycle combinational.

## Configuration
- `COM_INTC_SYNC_EN` defined: `irq_in` passes through a 2-flop synchroniser per bit ahead of edge detection. Latency becomes 4 cycles. Use for asynchronous sources.
- Undefined: `irq_in` is assumed synchronous to `clk`, with no synchroniser. Latency is 2 cycles.

## Structure
- Package `intc_pkg` holds:
  - register offset constants `INTC_PEND`, `INTC_MASK`, `INTC_EOI`, `INTC_SWI`, `INTC_STAT`;
  - the state enum `intc_state_t` {`INTC_IDLE`, `INTC_FIRE`, `INTC_SERVICE`};
  - the flag-byte valid-bit position.
- One sub-module, `intc_prio_enc`: a combinational lowest-index priority encoder, input `NSRC` bits, output `valid` and a 3-bit `id`.

## Test plan
- Reset, then read all five registers: each reads 8'h00 and `interrupt` stays 0.
- MASK=8'h04, raise `irq_in[2]` at edge k: `interrupt` high exactly one cycle, from k+1 to k+2. `com_rd`=8'h82 during the pulse, PEND[2]=0, STAT=8'h82 afterwards.
- MASK=8'hFF, raise bits 5 and 1 in the same cycle: fire id 1 first (flag 8'h81). Write EOI: fire id 5 one cycle later (flag 8'h85).
- In SERVICE, raise `irq_in[0]`: no pulse and PEND=8'h01. Write EOI: pulse after 2 edges, flag 8'h80.
- PEND W1C of bit 3 in the same cycle as a new edge on `irq_in[3]`: PEND[3] reads 1. SWI write 8'h10 with MASK=8'h10: pulse, flag 8'h84.
- Assert `rst` during SERVICE with PEND nonzero: after the edge, state IDLE, PEND=MASK=0, no pulse even when a source is raised with MASK still 0.
